// File: rtl/toy_bus_arb_pkg.sv
// Shared types and helpers for the toy_bus burst-lock arbiter.
package toy_bus_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned GRANT_CNT_W = 16;

  // Encodes a one-hot vector of up to 8 bits; returns 0 for an all-zero input.
  function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/toy_bus_age_mtx.sv
// Age matrix for the burst-lock arbiter: age_row[i*N+j]=1 means requester j is older than i.
module toy_bus_age_mtx #(
  parameter int unsigned N = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 upd_en,
  input  logic [$clog2(N)-1:0] upd_idx,
  output logic [N*N-1:0]       age_row
);

  localparam int unsigned IdxW = $clog2(N);

  logic [N*N-1:0] age_q, age_d;

  // The updated requester becomes youngest: everyone is older than it, it is older than nobody.
  always_comb begin
    age_d = age_q;
    if (upd_en) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (upd_idx == IdxW'(i)) begin
            age_d[i*N+j] = (j != i);
          end else if (upd_idx == IdxW'(j)) begin
            age_d[i*N+j] = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          age_q[i*N+j] <= (j < i);
        end
      end
    end else begin
      age_q <= age_d;
    end
  end

  assign age_row = age_q;

endmodule

// File: rtl/toy_bus_burst_lock_arb.sv
// Age-ordered toy_bus arbiter that locks the grant for a whole burst, with a forced release
// after MAX_BEATS beats. Optional per-requester grant counters: TOY_BUS_ARB_GRANT_CNT_EN.
module toy_bus_burst_lock_arb
  import toy_bus_arb_pkg::*;
#(
  parameter int unsigned N         = 2,
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned BEAT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N-1:0]                 req_vld,
  input  logic [N-1:0]                 req_last,
  output logic [N-1:0]                 req_rdy,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [N-1:0]                 grant,
  output logic [$clog2(N)-1:0]         grant_idx,
  output logic                         locked,
  output logic                         burst_cut
`ifdef TOY_BUS_ARB_GRANT_CNT_EN
  ,
  input  logic                         cnt_clr,
  output logic [N*GRANT_CNT_W-1:0]     grant_cnt
`endif
);

  localparam int unsigned IdxW = $clog2(N);

  arb_state_e        state_q, state_d;
  logic [IdxW-1:0]   lock_id_q, lock_id_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              burst_cut_q, burst_cut_d;

  logic [N*N-1:0]    age_row;
  logic [N-1:0]      sel;
  logic [IdxW-1:0]   sel_idx;
  logic [N-1:0]      lock_oh;
  logic              hs;
  logic              upd_en;
  logic [IdxW-1:0]   upd_idx;
  logic [7:0]        sel_pad, grant_pad;

  toy_bus_age_mtx #(
    .N(N)
  ) u_age_mtx (
    .clk    (clk),
    .rst_n  (rst_n),
    .upd_en (upd_en),
    .upd_idx(upd_idx),
    .age_row(age_row)
  );

  // Oldest valid requester: no other valid requester is older than it.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      sel[i] = req_vld[i] & ~|(age_row[i*N +: N] & req_vld);
    end
    sel_pad        = '0;
    sel_pad[N-1:0] = sel;
    sel_idx        = IdxW'(onehot2idx(sel_pad));
    lock_oh            = '0;
    lock_oh[lock_id_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      lock_id_q   <= '0;
      beat_cnt_q  <= '0;
      burst_cut_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_id_q   <= lock_id_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_cut_q <= burst_cut_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lock_id_d   = lock_id_q;
    beat_cnt_d  = beat_cnt_q;
    burst_cut_d = 1'b0;
    upd_en      = 1'b0;
    upd_idx     = (state_q == ARB_IDLE) ? sel_idx : lock_id_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (hs) begin
          if (req_last[sel_idx]) begin
            upd_en = 1'b1;
          end else begin
            state_d    = ARB_LOCKED;
            lock_id_d  = sel_idx;
            beat_cnt_d = BEAT_W'(1);
          end
        end
      end
      ARB_LOCKED: begin
        if (hs) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          if (req_last[lock_id_q]) begin
            state_d    = ARB_IDLE;
            beat_cnt_d = '0;
            upd_en     = 1'b1;
          end else if (beat_cnt_q == BEAT_W'(MAX_BEATS - 1)) begin
            state_d     = ARB_IDLE;
            beat_cnt_d  = '0;
            upd_en      = 1'b1;
            burst_cut_d = 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // A held lock keeps its grant even while the owner's valid is low.
  always_comb begin
    grant            = (state_q == ARB_LOCKED) ? lock_oh : sel;
    out_vld          = |(req_vld & grant);
    req_rdy          = grant & {N{out_rdy}};
    hs               = out_vld & out_rdy;
    grant_pad        = '0;
    grant_pad[N-1:0] = grant;
    grant_idx        = IdxW'(onehot2idx(grant_pad));
    locked           = (state_q == ARB_LOCKED);
    burst_cut        = burst_cut_q;
  end

`ifdef TOY_BUS_ARB_GRANT_CNT_EN
  for (genvar g = 0; g < N; g++) begin : gen_cnt
    logic [GRANT_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (cnt_clr) begin
        cnt_q <= '0;
      end else if (req_rdy[g] && req_vld[g] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + GRANT_CNT_W'(1);
      end
    end

    assign grant_cnt[g*GRANT_CNT_W +: GRANT_CNT_W] = cnt_q;
  end
`endif

endmodule
